// File: rtl/mips_rf_pkg.sv
// rtl/mips_rf_pkg.sv - shared widths, zero-register address and typedefs for the register file
package mips_rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int ZERO_ADDR = 0;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/mips_rf_pend_cnt.sv
// rtl/mips_rf_pend_cnt.sv - saturating pending-writer counter for one register
module mips_rf_pend_cnt #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] cnt_o,
  output logic              err_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  // A simultaneous reserve and release cancel out and can never be an error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) err_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/mips_regfile_scoreboard.sv
// rtl/mips_regfile_scoreboard.sv - register file with write bypass and per-register pending-write scoreboard
module mips_regfile_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int PEND_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
  input  logic [NUM_READ-1:0]        rd_used,
  output logic [NUM_READ*DATA_W-1:0] rd_data,
  output logic [NUM_READ-1:0]        rd_busy,
  output logic                       stall,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       resv_en,
  input  logic [ADDR_W-1:0]          resv_addr,
  output logic                       resv_err
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA    = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [PEND_W-1:0] cnt_w  [DEPTH];
  logic [DEPTH-1:0]  err_w;
  logic [NUM_READ-1:0] busy_w;
  logic              wr_ok, resv_ok;

  assign wr_ok   = wr_en   && !((ZERO_REG != 0) && (wr_addr == ZA));
  assign resv_ok = resv_en && !((ZERO_REG != 0) && (resv_addr == ZA));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pend
    logic inc_w, dec_w;
    assign inc_w = resv_ok && (resv_addr == ADDR_W'(g));
    assign dec_w = wr_ok   && (wr_addr   == ADDR_W'(g));

    mips_rf_pend_cnt #(
      .PEND_W(PEND_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (inc_w),
      .dec_i (dec_w),
      .cnt_o (cnt_w[g]),
      .err_o (err_w[g])
    );
  end

  // Each counter registers its own error, so the OR is already a registered pulse.
  assign resv_err = |err_w;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_w;
    logic              zero_w, hit_w, drain_w;

    assign addr_w  = rd_addr[i*ADDR_W +: ADDR_W];
    assign zero_w  = (ZERO_REG != 0) && (addr_w == ZA);
    assign hit_w   = (BYPASS != 0) && wr_ok && (wr_addr == addr_w);
    // The last outstanding writer lands this cycle and nobody re-reserves it.
    assign drain_w = hit_w && (cnt_w[addr_w] == PEND_W'(1))
                     && !(resv_ok && (resv_addr == addr_w));

    assign rd_data[i*DATA_W +: DATA_W] = zero_w ? '0 :
                                         hit_w  ? wr_data : regs_q[addr_w];
    assign busy_w[i] = !zero_w && (cnt_w[addr_w] != '0) && !drain_w;
  end

  assign rd_busy = busy_w;
  assign stall   = |(rd_used & busy_w);

endmodule
